// File: rtl/cipher_load_ctrl.sv
// Host-side sequencer for the processor wrapper: buffers ciphertext bytes, loads them
// into processor RAM, runs the CPU until it signals done, then streams the result bytes out.
module cipher_load_ctrl #(
    parameter int          BUF_LEN      = 108,
    parameter logic [11:0] RESULT_ADDR  = 12'd1700,
    parameter int          RESULT_LEN   = 108,
    parameter logic [23:0] EXEC_TIMEOUT = 24'd10_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        start,
    output logic [1:0]  cpu_en,
    output logic [1:0]  wrstate,
    output logic [7:0]  curr_index,
    output logic [7:0]  char_buffer_data,
    output logic [11:0] read_addr,
    input  logic [31:0] read_data,
    input  logic        done_flag,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        timeout_err
);
    localparam int CW = $clog2(BUF_LEN + 1);
    localparam int AW = $clog2(BUF_LEN);
    localparam int RW = $clog2(RESULT_LEN + 1);
    localparam logic [CW-1:0] BUF_FULL  = CW'(BUF_LEN);
    localparam logic [7:0]    IDX_LAST  = 8'(BUF_LEN - 1);
    localparam logic [RW-1:0] RIDX_LAST = RW'(RESULT_LEN - 1);
    localparam logic [23:0]   TCNT_LAST = EXEC_TIMEOUT - 24'd1;

    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_WRITE = 3'd1,
        S_EXEC  = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] count_r, count_s;
    logic [RW-1:0] ridx_r, ridx_s;
    logic [23:0]   tcnt_r, tcnt_s;
    logic [7:0]    buf_r [BUF_LEN];
    logic [1:0]    cpu_en_r, cpu_en_s, wrstate_r, wrstate_s;
    logic [7:0]    curr_index_r, curr_index_s, char_data_r, char_data_s;
    logic [7:0]    next_idx_s, out_data_r, out_data_s;
    logic [11:0]   read_addr_r, read_addr_s;
    logic          in_ready_r, in_ready_s, out_valid_r, out_valid_s;
    logic          busy_r, busy_s, timeout_err_r, timeout_err_s;
    logic          accept_s;
    logic          unused_s;

    // in_ready is only ever high while filling, so this is the complete accept condition
    assign accept_s = in_valid && in_ready_r;
    assign unused_s = ^read_data[31:8];

    // Byte buffer; deliberately unreset, a cleared count makes stale contents unreachable
    always_ff @(posedge clock) begin
        if (accept_s) begin
            buf_r[AW'(count_r)] <= in_data;
        end
    end

    // Next-state and next-output computation; every output is registered from these values
    always_comb begin
        state_s       = state_r;
        count_s       = count_r;
        ridx_s        = ridx_r;
        tcnt_s        = tcnt_r;
        cpu_en_s      = cpu_en_r;
        wrstate_s     = wrstate_r;
        curr_index_s  = curr_index_r;
        char_data_s   = char_data_r;
        read_addr_s   = read_addr_r;
        out_valid_s   = out_valid_r;
        out_data_s    = out_data_r;
        timeout_err_s = timeout_err_r;
        next_idx_s    = curr_index_r + 8'd1;
        case (state_r)
            S_FILL: begin
                count_s = accept_s ? count_r + CW'(1) : count_r;
                if (start && (count_s != {CW{1'b0}})) begin
                    state_s       = S_WRITE;
                    timeout_err_s = 1'b0;
                    cpu_en_s      = 2'b01;
                    wrstate_s     = 2'b10;
                    curr_index_s  = 8'd0;
                    // an empty buffer can only start if this very cycle's byte is slot 0
                    char_data_s   = (count_r == {CW{1'b0}}) ? in_data : buf_r[{AW{1'b0}}];
                end else begin
                    state_s = S_FILL;
                end
            end
            S_WRITE: begin
                if (curr_index_r == IDX_LAST) begin
                    state_s      = S_EXEC;
                    cpu_en_s     = 2'b10;
                    wrstate_s    = 2'b00;
                    curr_index_s = 8'd0;
                    char_data_s  = 8'd0;
                    tcnt_s       = 24'd0;
                end else begin
                    curr_index_s = next_idx_s;
                    char_data_s  = (next_idx_s < 8'(count_r)) ? buf_r[AW'(next_idx_s)] : 8'd0;
                end
            end
            S_EXEC: begin
                tcnt_s = tcnt_r + 24'd1;
                if (done_flag) begin
                    state_s     = S_RADDR;
                    cpu_en_s    = 2'b00;
                    ridx_s      = {RW{1'b0}};
                    read_addr_s = RESULT_ADDR;
                end else if (tcnt_r == TCNT_LAST) begin
                    state_s       = S_FILL;
                    cpu_en_s      = 2'b00;
                    timeout_err_s = 1'b1;
                    count_s       = {CW{1'b0}};
                end else begin
                    state_s = S_EXEC;
                end
            end
            S_RADDR: begin
                state_s = S_RDATA;
            end
            S_RDATA: begin
                state_s     = S_OUT;
                out_valid_s = 1'b1;
                out_data_s  = read_data[7:0];
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    if (ridx_r == RIDX_LAST) begin
                        state_s = S_FILL;
                        count_s = {CW{1'b0}};
                    end else begin
                        state_s     = S_RADDR;
                        ridx_s      = ridx_r + RW'(1);
                        read_addr_s = RESULT_ADDR + 12'(ridx_s);
                    end
                end else begin
                    state_s = S_OUT;
                end
            end
            default: begin
                state_s     = S_FILL;
                count_s     = {CW{1'b0}};
                cpu_en_s    = 2'b00;
                wrstate_s   = 2'b00;
                out_valid_s = 1'b0;
            end
        endcase
        in_ready_s = (state_s == S_FILL) && (count_s < BUF_FULL);
        busy_s     = (state_s != S_FILL);
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= S_FILL;
            count_r       <= {CW{1'b0}};
            ridx_r        <= {RW{1'b0}};
            tcnt_r        <= 24'd0;
            cpu_en_r      <= 2'b00;
            wrstate_r     <= 2'b00;
            curr_index_r  <= 8'd0;
            char_data_r   <= 8'd0;
            read_addr_r   <= 12'd0;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_data_r    <= 8'd0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            count_r       <= count_s;
            ridx_r        <= ridx_s;
            tcnt_r        <= tcnt_s;
            cpu_en_r      <= cpu_en_s;
            wrstate_r     <= wrstate_s;
            curr_index_r  <= curr_index_s;
            char_data_r   <= char_data_s;
            read_addr_r   <= read_addr_s;
            in_ready_r    <= in_ready_s;
            out_valid_r   <= out_valid_s;
            out_data_r    <= out_data_s;
            busy_r        <= busy_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    assign in_ready         = in_ready_r;
    assign cpu_en           = cpu_en_r;
    assign wrstate          = wrstate_r;
    assign curr_index       = curr_index_r;
    assign char_buffer_data = char_data_r;
    assign read_addr        = read_addr_r;
    assign out_valid        = out_valid_r;
    assign out_data         = out_data_r;
    assign busy             = busy_r;
    assign timeout_err      = timeout_err_r;
endmodule
